// File: rtl/icon_scheduler.sv
// rtl/icon_scheduler.sv - double-buffered sprite slot scheduler with collision counter
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   video_on             display active region
//   pixel_row/column     current pixel coordinate (10 bits each)
//   frame_start          one-cycle pulse at the first pixel of each frame
//   cfg_we/slot/data     shadow slot write {enable, code[3:0], y[9:0], x[9:0]}
//   commit_req           request to copy shadow slots to active at next frame_start
//   commit_ack           one-cycle pulse after the copy has happened
//   commit_pending       request accepted but not yet applied
//   icon                 winning sprite code, registered, 0 = no icon
//   collision_count      multi-sprite pixel count of the previous frame (saturating)
module icon_scheduler #(
    parameter int N_SLOTS   = 4,
    parameter int ICON_SIZE = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  pixel_row,
    input  logic [9:0]  pixel_column,
    input  logic        frame_start,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_slot,
    input  logic [24:0] cfg_data,
    input  logic        commit_req,
    output logic        commit_ack,
    output logic        commit_pending,
    output logic [3:0]  icon,
    output logic [15:0] collision_count
);

    localparam logic [10:0] SIZE11 = 11'(ICON_SIZE);

    logic       sh_en   [N_SLOTS];
    logic [3:0] sh_code [N_SLOTS];
    logic [9:0] sh_y    [N_SLOTS];
    logic [9:0] sh_x    [N_SLOTS];
    logic       act_en  [N_SLOTS];
    logic [3:0] act_code[N_SLOTS];
    logic [9:0] act_y   [N_SLOTS];
    logic [9:0] act_x   [N_SLOTS];

    logic [N_SLOTS-1:0] hit;
    logic [3:0]         win_code;
    logic [2:0]         hit_cnt;
    logic               pixel_coll;
    logic               commit_fire;
    logic [15:0]        acc;

    // A request arriving on the frame_start edge itself is honoured immediately.
    assign commit_fire = frame_start && (commit_pending || commit_req);

    // Slot storage. Non-blocking semantics make a coincident write land only in
    // shadow while the copy takes the pre-write shadow contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                sh_en[s]    <= 1'b0;
                sh_code[s]  <= 4'd0;
                sh_y[s]     <= 10'd0;
                sh_x[s]     <= 10'd0;
                act_en[s]   <= 1'b0;
                act_code[s] <= 4'd0;
                act_y[s]    <= 10'd0;
                act_x[s]    <= 10'd0;
            end
        end else begin
            for (int s = 0; s < N_SLOTS; s++) begin
                if (commit_fire) begin
                    act_en[s]   <= sh_en[s];
                    act_code[s] <= sh_code[s];
                    act_y[s]    <= sh_y[s];
                    act_x[s]    <= sh_x[s];
                end
                // Indices at or above N_SLOTS match no slot and are dropped.
                if (cfg_we && cfg_slot == 2'(s)) begin
                    sh_en[s]   <= cfg_data[24];
                    sh_code[s] <= cfg_data[23:20];
                    sh_y[s]    <= cfg_data[19:10];
                    sh_x[s]    <= cfg_data[9:0];
                end
            end
        end
    end

    // Commit handshake: requests do not queue, one pending flag is enough.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_pending <= 1'b0;
            commit_ack     <= 1'b0;
        end else begin
            commit_ack <= commit_fire;
            if (commit_fire) begin
                commit_pending <= 1'b0;
            end else if (commit_req) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Hit test at 11 bits so x+ICON_SIZE past 1023 clips instead of wrapping.
    always_comb begin
        hit = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            hit[s] = act_en[s] && (act_code[s] != 4'd0)
                  && ({1'b0, pixel_column} >= {1'b0, act_x[s]})
                  && ({1'b0, pixel_column} <  ({1'b0, act_x[s]} + SIZE11))
                  && ({1'b0, pixel_row}    >= {1'b0, act_y[s]})
                  && ({1'b0, pixel_row}    <  ({1'b0, act_y[s]} + SIZE11));
        end
    end

    // Walk from the highest slot down so the lowest-index hit is left standing.
    always_comb begin
        win_code = 4'd0;
        hit_cnt  = 3'd0;
        for (int s = N_SLOTS - 1; s >= 0; s--) begin
            if (hit[s]) begin
                win_code = act_code[s];
                hit_cnt  = hit_cnt + 3'd1;
            end
        end
    end

    assign pixel_coll = video_on && (hit_cnt >= 3'd2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            icon <= 4'd0;
        end else begin
            icon <= video_on ? win_code : 4'd0;
        end
    end

    // At frame_start the finished frame's total is published and this cycle's
    // pixel becomes the first contribution to the new frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc             <= 16'd0;
            collision_count <= 16'd0;
        end else if (frame_start) begin
            collision_count <= acc;
            acc             <= pixel_coll ? 16'd1 : 16'd0;
        end else if (pixel_coll && acc != 16'hFFFF) begin
            acc <= acc + 16'd1;
        end
    end

endmodule

// File: tb/tb_icon_scheduler.sv
// tb/tb_icon_scheduler.sv - scoreboard bench for icon_scheduler
module tb_icon_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        video_on;
    logic [9:0]  pixel_row;
    logic [9:0]  pixel_column;
    logic        frame_start;
    logic        cfg_we;
    logic [1:0]  cfg_slot;
    logic [24:0] cfg_data;
    logic        commit_req;
    logic        commit_ack;
    logic        commit_pending;
    logic [3:0]  icon;
    logic [15:0] collision_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];

    always #5 clock = ~clock;

    icon_scheduler #(.N_SLOTS(3), .ICON_SIZE(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .video_on       (video_on),
        .pixel_row      (pixel_row),
        .pixel_column   (pixel_column),
        .frame_start    (frame_start),
        .cfg_we         (cfg_we),
        .cfg_slot       (cfg_slot),
        .cfg_data       (cfg_data),
        .commit_req     (commit_req),
        .commit_ack     (commit_ack),
        .commit_pending (commit_pending),
        .icon           (icon),
        .collision_count(collision_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int slot, input logic en, input logic [3:0] code, input int y, input int x);
        cfg_we   = 1'b1;
        cfg_slot = 2'(slot);
        cfg_data = {en, code, 10'(y), 10'(x)};
        step();
        cfg_we   = 1'b0;
    endtask

    // Request, then a frame_start with video off so no pixel is counted.
    task automatic commit();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        check("pending_set", commit_pending, 1);
        check("ack_early", commit_ack, 0);
        frame_start = 1'b1;
        video_on    = 1'b0;
        step();
        frame_start = 1'b0;
        check("ack_pulse", commit_ack, 1);
        check("pending_clr", commit_pending, 0);
        step();
        check("ack_drop", commit_ack, 0);
    endtask

    task automatic pix(input int r, input int c, input logic von, input logic [3:0] exp);
        pixel_row    = 10'(r);
        pixel_column = 10'(c);
        video_on     = von;
        exp_q.push_back(exp);
        step();
        check($sformatf("icon(%0d,%0d)", r, c), icon, exp_q.pop_front());
    endtask

    initial begin
        reset = 1'b1; video_on = 1'b0; pixel_row = '0; pixel_column = '0;
        frame_start = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_data = '0; commit_req = 1'b0;
        step(); step();
        check("rst_icon", icon, 0);
        check("rst_ack", commit_ack, 0);
        check("rst_pending", commit_pending, 0);
        check("rst_count", collision_count, 0);
        reset = 1'b0;
        step();

        // Nothing visible before any commit.
        pix(100, 200, 1, 0);

        // Basic sprite.
        wr(0, 1, 4'h3, 100, 200);
        pix(100, 200, 1, 0);
        commit();
        pix(100, 200, 1, 3);
        pix(100, 216, 1, 0);
        pix(116, 200, 1, 0);
        pix(115, 215, 1, 3);
        pix(99, 200, 1, 0);
        pix(100, 199, 1, 0);
        pix(100, 200, 0, 0);

        // Priority and collision over a 20x20 window.
        wr(0, 1, 4'h2, 0, 0);
        wr(1, 1, 4'h5, 0, 0);
        commit();
        check("count_after_single", collision_count, 0);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++)
                pix(r, c, 1, (r < 16 && c < 16) ? 4'h2 : 4'h0);
        frame_start = 1'b1; video_on = 1'b0;
        step();
        frame_start = 1'b0;
        check("count_256", collision_count, 256);
        check("no_ack_plain_frame", commit_ack, 0);
        // Collision on the frame_start cycle reloads the accumulator to 1.
        frame_start = 1'b1;
        pix(0, 0, 1, 2);
        frame_start = 1'b0;
        check("count_empty_frame", collision_count, 0);
        frame_start = 1'b1;
        pix(40, 40, 0, 0);
        frame_start = 1'b0;
        check("count_reload_1", collision_count, 1);

        // Shadow isolation: write without commit.
        pix(5, 5, 1, 2);
        wr(0, 1, 4'h2, 0, 300);
        frame_start = 1'b1;
        pix(5, 5, 1, 2);
        frame_start = 1'b0;
        check("iso_ack", commit_ack, 0);
        check("iso_pending", commit_pending, 0);
        pix(5, 5, 1, 2);
        pix(5, 300, 1, 0);

        // Clipping near 1023, plus an out-of-range slot write that must be dropped.
        wr(0, 0, 4'h2, 0, 0);
        wr(1, 1, 4'h9, 1020, 500);
        wr(2, 1, 4'h7, 0, 1020);
        wr(3, 1, 4'hA, 0, 0);
        commit();
        for (int c = 1020; c < 1024; c++) pix(5, c, 1, 7);
        for (int c = 0; c < 12; c++) pix(5, c, 1, 0);
        for (int r = 1020; r < 1024; r++) pix(r, 500, 1, 9);
        for (int r = 0; r < 12; r++) pix(r, 500, 1, 0);
        pix(0, 0, 1, 0);

        // Write, request and frame_start in one cycle.
        cfg_we = 1'b1; cfg_slot = 2'd2; cfg_data = {1'b1, 4'h7, 10'd0, 10'd40};
        commit_req = 1'b1; frame_start = 1'b1; video_on = 1'b0;
        step();
        cfg_we = 1'b0; commit_req = 1'b0; frame_start = 1'b0;
        check("sim_ack", commit_ack, 1);
        check("sim_pending", commit_pending, 0);
        pix(5, 1020, 1, 7);
        pix(5, 40, 1, 0);
        commit();
        pix(5, 40, 1, 7);
        pix(5, 1020, 1, 0);

        // Reset in mid-operation with a pending commit and a nonzero accumulator.
        wr(0, 1, 4'h3, 5, 40);
        commit();
        pix(5, 40, 1, 3);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        check("pre_rst_pending", commit_pending, 1);
        check("pre_rst_icon", icon, 3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_icon", icon, 0);
        check("mid_rst_pending", commit_pending, 0);
        check("mid_rst_ack", commit_ack, 0);
        check("mid_rst_count", collision_count, 0);
        step();
        reset = 1'b0;
        video_on = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("post_rst_ack", commit_ack, 0);
        check("post_rst_count", collision_count, 0);
        pix(5, 40, 1, 0);
        pix(0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
